// File: rtl/dispatch_queue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_queue_ctrl
//  Purpose  : Circular-FIFO controller driving the dispatch RAM, with a
//             2-entry prefetch buffer that hides the RAM's 1-cycle read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module dispatch_queue_ctrl #(
    parameter int CORE        = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [DATA_WIDTH-1:0]  push_data,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic                   ram_write,
    output logic [INDEX_WIDTH-1:0] ram_in_address,
    output logic [DATA_WIDTH-1:0]  ram_in_data,
    output logic                   ram_read,
    output logic [INDEX_WIDTH-1:0] ram_out_address,
    input  logic [DATA_WIDTH-1:0]  ram_out_data,
    output logic [INDEX_WIDTH+1:0] occupancy,
    input  logic                   report
);

    logic [INDEX_WIDTH-1:0] r_head;
    logic [INDEX_WIDTH-1:0] r_tail;
    logic [INDEX_WIDTH:0]   r_ram_count;
    logic                   r_inflight;
    logic [1:0]             r_buf_count;
    logic [DATA_WIDTH-1:0]  r_buf [2];
    logic                   r_buf_rd;
    logic                   r_buf_wr;
    logic [31:0]            r_cycle;

    logic                   w_push_fire;
    logic                   w_pop_fire;
    logic                   w_ram_read;
    logic [2:0]             w_pending;

    // RAM count never exceeds DEPTH, so its MSB alone flags "full".
    assign push_ready  = ~r_ram_count[INDEX_WIDTH];
    assign w_push_fire = push_valid & push_ready;
    assign pop_valid   = (r_buf_count != 2'd0);
    assign w_pop_fire  = pop_valid & pop_ready;

    // Slots the buffer will still owe after this cycle's pop; prefetch only if one is free.
    assign w_pending  = {1'b0, r_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop_fire};
    assign w_ram_read = (r_ram_count != '0) && (w_pending < 3'd2);

    assign ram_write       = w_push_fire;
    assign ram_in_address  = r_tail;
    assign ram_in_data     = push_data;
    assign ram_read        = w_ram_read;
    assign ram_out_address = r_head;

    assign pop_data  = r_buf[r_buf_rd];
    assign occupancy = {1'b0, r_ram_count}
                     + {{(INDEX_WIDTH+1){1'b0}}, r_inflight}
                     + {{INDEX_WIDTH{1'b0}}, r_buf_count};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_ram_count <= '0;
            r_inflight  <= 1'b0;
            r_buf_count <= 2'd0;
            r_buf_rd    <= 1'b0;
            r_buf_wr    <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_cycle     <= 32'd0;
        end else begin
            r_cycle     <= r_cycle + 32'd1;
            r_ram_count <= r_ram_count + {{INDEX_WIDTH{1'b0}}, w_push_fire}
                                       - {{INDEX_WIDTH{1'b0}}, w_ram_read};
            r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_pop_fire};
            r_inflight  <= w_ram_read;
            if (w_push_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_ram_read) begin
                r_head <= r_head + 1'b1;
            end
            if (r_inflight) begin
                r_buf[r_buf_wr] <= ram_out_data;
                r_buf_wr        <= ~r_buf_wr;
            end
            if (w_pop_fire) begin
                r_buf_rd <= ~r_buf_rd;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report) begin
            $display("core %0d cycle %0d head %0d tail %0d ram_count %0d inflight %0d buf_count %0d push %0b/%0b pop %0b/%0b",
                     CORE, r_cycle, r_head, r_tail, r_ram_count, r_inflight, r_buf_count,
                     push_valid, push_ready, pop_valid, pop_ready);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_queue_ctrl
//  Purpose  : Scoreboard bench for dispatch_queue_ctrl with a 4-deep RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue_ctrl;

    localparam int c_DW = 32;
    localparam int c_IW = 2;

    logic            clock;
    logic            reset;
    logic            push_valid;
    logic            push_ready;
    logic [c_DW-1:0] push_data;
    logic            pop_valid;
    logic            pop_ready;
    logic [c_DW-1:0] pop_data;
    logic            ram_write;
    logic [c_IW-1:0] ram_in_address;
    logic [c_DW-1:0] ram_in_data;
    logic            ram_read;
    logic [c_IW-1:0] ram_out_address;
    logic [c_DW-1:0] ram_out_data;
    logic [c_IW+1:0] occupancy;
    logic            report;

    dispatch_queue_ctrl #(
        .CORE        (0),
        .DATA_WIDTH  (c_DW),
        .INDEX_WIDTH (c_IW)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_data       (push_data),
        .pop_valid       (pop_valid),
        .pop_ready       (pop_ready),
        .pop_data        (pop_data),
        .ram_write       (ram_write),
        .ram_in_address  (ram_in_address),
        .ram_in_data     (ram_in_data),
        .ram_read        (ram_read),
        .ram_out_address (ram_out_address),
        .ram_out_data    (ram_out_data),
        .occupancy       (occupancy),
        .report          (report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM standing in for dispatch_interface.
    logic [c_DW-1:0] r_mem [4];
    always @(posedge clock) begin
        if (ram_write) r_mem[ram_in_address] <= ram_in_data;
        if (ram_read)  ram_out_data <= r_mem[ram_out_address];
    end

    int              n_checks = 0;
    int              n_fail   = 0;
    int              n_pops   = 0;
    logic [c_DW-1:0] sb [$];
    logic [c_IW-1:0] exp_tail = '0;
    logic [c_IW-1:0] exp_head = '0;
    logic [c_IW-1:0] last_waddr = '0;
    logic            saw_wrap = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: pushes recorded on handshake, pops compared in order.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            exp_tail = '0;
            exp_head = '0;
        end else begin
            chk("ram_write", {63'd0, ram_write}, {63'd0, push_valid & push_ready});
            if (push_valid && push_ready) begin
                chk("wr_addr", {62'd0, ram_in_address}, {62'd0, exp_tail});
                chk("wr_data", {32'd0, ram_in_data}, {32'd0, push_data});
                if (last_waddr == 2'd3 && ram_in_address == 2'd0) saw_wrap = 1'b1;
                last_waddr = ram_in_address;
                exp_tail   = exp_tail + 1'b1;
                sb.push_back(push_data);
            end
            if (ram_read) begin
                chk("rd_addr", {62'd0, ram_out_address}, {62'd0, exp_head});
                exp_head = exp_head + 1'b1;
            end
            if (pop_valid && pop_ready) begin
                n_pops++;
                chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) chk("pop_data", {32'd0, pop_data}, {32'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        int accepted;
        int next;
        int base;
        int pushed;

        reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        report     = 1'b0;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_push_ready", {63'd0, push_ready}, 64'd1);
        chk("rst_pop_valid",  {63'd0, pop_valid},  64'd0);
        chk("rst_ram_write",  {63'd0, ram_write},  64'd0);
        chk("rst_ram_read",   {63'd0, ram_read},   64'd0);
        chk("rst_occupancy",  {60'd0, occupancy},  64'd0);
        chk("rst_pop_data",   {32'd0, pop_data},   64'd0);

        // Single entry latency
        tick();
        push_valid = 1'b1;
        push_data  = 32'hDEADBEEF;
        @(negedge clock);
        chk("c0_ram_write", {63'd0, ram_write}, 64'd1);
        chk("c0_wr_addr",   {62'd0, ram_in_address}, 64'd0);
        tick();
        push_valid = 1'b0;
        @(negedge clock);
        chk("c1_ram_read",  {63'd0, ram_read}, 64'd1);
        chk("c1_rd_addr",   {62'd0, ram_out_address}, 64'd0);
        chk("c1_pop_valid", {63'd0, pop_valid}, 64'd0);
        tick();
        @(negedge clock);
        chk("c2_pop_valid", {63'd0, pop_valid}, 64'd0);
        tick();
        @(negedge clock);
        chk("c3_pop_valid", {63'd0, pop_valid}, 64'd1);
        chk("c3_pop_data",  {32'd0, pop_data}, 64'hDEADBEEF);
        repeat (3) begin
            tick();
            @(negedge clock);
            chk("hold_valid", {63'd0, pop_valid}, 64'd1);
            chk("hold_data",  {32'd0, pop_data}, 64'hDEADBEEF);
        end
        tick();
        pop_ready = 1'b1;
        @(negedge clock);
        tick();
        pop_ready = 1'b0;
        @(negedge clock);
        chk("single_empty_valid", {63'd0, pop_valid}, 64'd0);
        chk("single_empty_occ",   {60'd0, occupancy}, 64'd0);

        // Fill
        tick();
        accepted = 0;
        for (int i = 1; i <= 8; i++) begin
            push_valid = 1'b1;
            push_data  = i;
            @(negedge clock);
            if (push_ready) accepted++;
            tick();
        end
        push_valid = 1'b0;
        @(negedge clock);
        chk("fill_accepted",   accepted, 64'd6);
        chk("fill_occupancy",  {60'd0, occupancy}, 64'd6);
        chk("fill_push_ready", {63'd0, push_ready}, 64'd0);
        tick();
        pop_ready = 1'b1;
        report    = 1'b1;
        @(negedge clock);
        tick();
        pop_ready = 1'b0;
        report    = 1'b0;
        @(negedge clock);
        chk("fill_reopen", {63'd0, push_ready}, 64'd1);
        tick();
        pop_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (occupancy == 0) break;
            tick();
        end
        chk("drain_occ", {60'd0, occupancy}, 64'd0);
        chk("drain_sb",  sb.size(), 64'd0);
        tick();
        pop_ready = 1'b0;

        // Streaming
        next = 1;
        base = n_pops;
        for (int c = 0; c < 106; c++) begin
            push_valid = (next <= 100);
            push_data  = next;
            pop_ready  = 1'b1;
            @(negedge clock);
            if (c >= 3 && c <= 102) chk("stream_no_gap", {63'd0, pop_valid}, 64'd1);
            chk("stream_occ_le3", {63'd0, occupancy <= 3}, 64'd1);
            if (push_valid && push_ready) next++;
            tick();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk("stream_pops", n_pops - base, 64'd100);
        chk("stream_sb",   sb.size(), 64'd0);

        // Wrap with random gaps
        saw_wrap = 1'b0;
        pushed   = 0;
        base     = n_pops;
        for (int k = 0; k < 400 && (n_pops - base) < 10; k++) begin
            push_valid = (pushed < 10) && ($urandom_range(0, 1) == 1);
            push_data  = 32'hA000 + pushed;
            pop_ready  = ($urandom_range(0, 1) == 1);
            @(negedge clock);
            if (push_valid && push_ready) pushed++;
            tick();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk("wrap_pops", n_pops - base, 64'd10);
        chk("wrap_sb",   sb.size(), 64'd0);
        chk("wrap_seen", {63'd0, saw_wrap}, 64'd1);

        // Reset mid-operation with a read in flight
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_data  = 32'h600 + i;
            @(negedge clock);
            if (i == 2) chk("midrst_ram_read", {63'd0, ram_read}, 64'd1);
            tick();
        end
        push_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_pop_valid", {63'd0, pop_valid}, 64'd0);
        chk("midrst_occupancy", {60'd0, occupancy}, 64'd0);
        chk("midrst_pop_data",  {32'd0, pop_data}, 64'd0);
        repeat (4) begin
            tick();
            @(negedge clock);
            chk("midrst_stays_empty", {63'd0, pop_valid}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
